// File: rtl/frame_bank_scheduler_if.sv
// Bank-scheduler bus: frame-event inputs from the video paths and the
// bank/base-address outputs consumed by the AXI write and read engines.
interface frame_bank_scheduler_if #(
    parameter int unsigned NUM_CH          = 5,
    parameter int unsigned CTRL_ADDR_WIDTH = 28
);
    logic [NUM_CH-1:0]                 wr_frame_done;
    logic                              rd_frame_start;
    logic [NUM_CH-1:0]                 freeze;
    logic [2*NUM_CH-1:0]               wr_bank;
    logic [2*NUM_CH-1:0]               rd_bank;
    logic [NUM_CH*CTRL_ADDR_WIDTH-1:0] wr_base_addr;
    logic [NUM_CH*CTRL_ADDR_WIDTH-1:0] rd_base_addr;
    logic [NUM_CH-1:0]                 rd_frame_valid;
    logic [8*NUM_CH-1:0]               drop_cnt;

    modport master (
        output wr_frame_done, rd_frame_start, freeze,
        input  wr_bank, rd_bank, wr_base_addr, rd_base_addr, rd_frame_valid, drop_cnt
    );

    modport slave (
        input  wr_frame_done, rd_frame_start, freeze,
        output wr_bank, rd_bank, wr_base_addr, rd_base_addr, rd_frame_valid, drop_cnt
    );
endinterface

// File: rtl/frame_bank_scheduler.sv
// Per-channel triple-buffer scheduler: the writer rotates through the banks
// the reader is not using; the reader latches the newest complete bank at vsync.
module frame_bank_scheduler #(
    parameter int unsigned                   NUM_CH          = 5,
    parameter int unsigned                   CTRL_ADDR_WIDTH = 28,
    parameter logic [CTRL_ADDR_WIDTH-1:0]    BASE_ADDR       = 28'h0,
    parameter logic [CTRL_ADDR_WIDTH-1:0]    CH_STRIDE       = 28'h040_0000,
    parameter logic [CTRL_ADDR_WIDTH-1:0]    FRAME_STRIDE    = 28'h010_0000
) (
    input  logic                  ddr_clk,
    input  logic                  rst,
    frame_bank_scheduler_if.slave bus
);
    localparam int unsigned AW = CTRL_ADDR_WIDTH;

    logic [NUM_CH-1:0][1:0]    wr_bank_q,   wr_bank_d;
    logic [NUM_CH-1:0][1:0]    rd_bank_q,   rd_bank_d;
    logic [NUM_CH-1:0][1:0]    last_done_q, last_done_d;
    logic [NUM_CH-1:0]         have_new_q,  have_new_d;
    logic [NUM_CH-1:0]         valid_q,     valid_d;
    logic [NUM_CH-1:0][7:0]    drop_cnt_q,  drop_cnt_d;

    logic [NUM_CH-1:0]         done_c;
    logic [NUM_CH-1:0]         take_c;
    logic [NUM_CH-1:0][AW-1:0] wr_addr_c;
    logic [NUM_CH-1:0][AW-1:0] rd_addr_c;

    assign done_c = bus.wr_frame_done;
    // Reader only switches when there is something newer than what it shows.
    assign take_c = {NUM_CH{bus.rd_frame_start}} & ~bus.freeze & (have_new_q | done_c);

    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        last_done_d = last_done_q;
        have_new_d  = have_new_q;
        valid_d     = valid_q;
        drop_cnt_d  = drop_cnt_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (done_c[ch]) begin
                last_done_d[ch] = wr_bank_q[ch];
                // Only bank left over when writer and reader occupy the other two.
                wr_bank_d[ch]   = 2'd3 - wr_bank_q[ch] - rd_bank_q[ch];
                have_new_d[ch]  = 1'b1;
                if (have_new_q[ch] && (drop_cnt_q[ch] != 8'hFF)) begin
                    drop_cnt_d[ch] = drop_cnt_q[ch] + 8'd1;
                end
            end
            if (take_c[ch]) begin
                rd_bank_d[ch]  = done_c[ch] ? wr_bank_q[ch] : last_done_q[ch];
                have_new_d[ch] = 1'b0;
                valid_d[ch]    = 1'b1;
            end
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            wr_bank_q   <= '0;
            rd_bank_q   <= {NUM_CH{2'd1}};
            last_done_q <= {NUM_CH{2'd1}};
            have_new_q  <= '0;
            valid_q     <= '0;
            drop_cnt_q  <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            last_done_q <= last_done_d;
            have_new_q  <= have_new_d;
            valid_q     <= valid_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Base addresses follow the registered banks directly, wrapping at AW bits.
    always_comb begin
        wr_addr_c = '0;
        rd_addr_c = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wr_addr_c[ch] = BASE_ADDR + AW'(ch) * CH_STRIDE + AW'(wr_bank_q[ch]) * FRAME_STRIDE;
            rd_addr_c[ch] = BASE_ADDR + AW'(ch) * CH_STRIDE + AW'(rd_bank_q[ch]) * FRAME_STRIDE;
        end
    end

    assign bus.wr_bank        = wr_bank_q;
    assign bus.rd_bank        = rd_bank_q;
    assign bus.rd_frame_valid = valid_q;
    assign bus.drop_cnt       = drop_cnt_q;
    assign bus.wr_base_addr   = wr_addr_c;
    assign bus.rd_base_addr   = rd_addr_c;
endmodule
